// File: rtl/cavlc_bit_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : cavlc_bit_accumulator_if
//  Description : Code-word input / bitstream-word output bundle of the CAVLC
//                bit accumulator. The master side is the producer of code
//                words and the consumer of bitstream words; the slave side is
//                the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cavlc_bit_accumulator_if #(
    parameter int CODE_W = 19,
    parameter int WORD_W = 32
);
    localparam int LEN_W = $clog2(CODE_W + 1);
    localparam int NB_W  = $clog2(WORD_W + 1);

    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code_bits;
    logic [LEN_W-1:0]  code_len;
    logic              flush;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic [NB_W-1:0]   word_nbits;
    logic              word_last;
    logic              flush_done;
    logic [31:0]       bit_count;

    modport master (
        output code_valid, code_bits, code_len, flush, word_ready,
        input  code_ready, word_valid, word_data, word_nbits, word_last,
               flush_done, bit_count
    );

    modport slave (
        input  code_valid, code_bits, code_len, flush, word_ready,
        output code_ready, word_valid, word_data, word_nbits, word_last,
               flush_done, bit_count
    );
endinterface
`default_nettype wire

// File: rtl/cavlc_bit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : cavlc_bit_accumulator
//  Description : Packs left-aligned variable-length CAVLC code words MSB-first
//                into a contiguous bitstream and emits 32-bit words over a
//                valid/ready handshake. A flush drains the buffer and emits a
//                zero-padded final partial word tagged with its bit count.
//  Revision    : 1.0 - initial release
// ============================================================================
module cavlc_bit_accumulator #(
    parameter int CODE_W = 19,
    parameter int WORD_W = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    cavlc_bit_accumulator_if.slave      bus
);
    // The buffer holds one full output word plus the largest code word that
    // can arrive while that word is still waiting to leave.
    localparam int BUF_W = CODE_W + WORD_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int LEN_W = $clog2(CODE_W + 1);
    localparam int NB_W  = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] C_WORD_CNT = CNT_W'(WORD_W);
    localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(CODE_W);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   bitbuf_q, bitbuf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        bit_count_q, bit_count_d;
    logic               word_valid_q, word_valid_d;
    logic [NB_W-1:0]    word_nbits_q, word_nbits_d;
    logic               word_last_q, word_last_d;
    logic               flush_done_q, flush_done_d;

    logic               w_pop;
    logic               w_code_ready;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len;
    logic [CODE_W-1:0]  w_code_masked;
    logic [BUF_W-1:0]   w_buf_popped;
    logic [CNT_W-1:0]   w_cnt_popped;

    // Handshake decode; word_ready feeds code_ready combinationally so a
    // full buffer can take a new code in the same cycle its word leaves.
    always_comb begin
        w_pop        = word_valid_q & bus.word_ready;
        w_code_ready = (state_q == ST_RUN) & ((cnt_q < C_WORD_CNT) | w_pop);
        w_accept     = bus.code_valid & w_code_ready;
        w_len        = (bus.code_len > C_MAX_LEN) ? C_MAX_LEN : bus.code_len;
        // Keep only the top w_len bits of the left-aligned code.
        w_code_masked = bus.code_bits & ~({CODE_W{1'b1}} >> w_len);
    end

    // Next buffer state: the outgoing word is removed first, then the new
    // code is appended directly behind whatever bits remain.
    always_comb begin
        w_buf_popped = bitbuf_q;
        w_cnt_popped = cnt_q;
        if (w_pop) begin
            w_buf_popped = bitbuf_q << WORD_W;
            // A partial (final) word empties the buffer completely.
            w_cnt_popped = (cnt_q >= C_WORD_CNT) ? (cnt_q - C_WORD_CNT) : '0;
        end

        bitbuf_d    = w_buf_popped;
        cnt_d       = w_cnt_popped;
        bit_count_d = bit_count_q;
        if (w_accept) begin
            bitbuf_d    = w_buf_popped
                        | ({w_code_masked, {WORD_W{1'b0}}} >> w_cnt_popped);
            cnt_d       = w_cnt_popped + CNT_W'(w_len);
            bit_count_d = bit_count_q + 32'(w_len);
        end
    end

    // Flush sequencing and the registered view of the output word.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    // Nothing left to drain: report completion right away.
                    if (cnt_d == '0) begin
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    flush_done_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        word_valid_d = (cnt_d >= C_WORD_CNT)
                     | ((state_d == ST_DRAIN) & (cnt_d != '0));
        word_last_d  = (state_d == ST_DRAIN) & (cnt_d != '0)
                     & (cnt_d < C_WORD_CNT);
        word_nbits_d = (cnt_d >= C_WORD_CNT) ? NB_W'(WORD_W) : NB_W'(cnt_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            bitbuf_q     <= '0;
            cnt_q        <= '0;
            bit_count_q  <= '0;
            word_valid_q <= 1'b0;
            word_nbits_q <= '0;
            word_last_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitbuf_q     <= bitbuf_d;
            cnt_q        <= cnt_d;
            bit_count_q  <= bit_count_d;
            word_valid_q <= word_valid_d;
            word_nbits_q <= word_nbits_d;
            word_last_q  <= word_last_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign bus.code_ready = w_code_ready;
    assign bus.word_valid = word_valid_q;
    assign bus.word_data  = bitbuf_q[BUF_W-1 -: WORD_W];
    assign bus.word_nbits = word_nbits_q;
    assign bus.word_last  = word_last_q;
    assign bus.flush_done = flush_done_q;
    assign bus.bit_count  = bit_count_q;

endmodule
`default_nettype wire
